// File: rtl/osnt_rate_monitor_pkg.sv
// osnt_rate_monitor_pkg: shared types and arithmetic helpers for the OSNT rate monitor.
package osnt_rate_monitor_pkg;

    localparam int STRB_W     = 32;
    localparam int BYTE_CNT_W = $clog2(STRB_W + 1);

    typedef enum logic {IDLE, RUN} state_t;

    function automatic logic [BYTE_CNT_W-1:0] popcount(input logic [STRB_W-1:0] v);
        logic [BYTE_CNT_W-1:0] n;
        n = '0;
        for (int i = 0; i < STRB_W; i++) n = n + BYTE_CNT_W'(v[i]);
        return n;
    endfunction

    // Clamps a + b to 2^w-1; w must stay below 64.
    function automatic logic [63:0] sat_add(input logic [63:0] a, input logic [63:0] b,
                                            input int unsigned w);
        logic [64:0] sum;
        logic [64:0] max;
        sum = {1'b0, a} + {1'b0, b};
        max = (65'd1 << w) - 65'd1;
        return (sum > max) ? max[63:0] : sum[63:0];
    endfunction

endpackage

// File: rtl/osnt_axis_pipe_reg.sv
// osnt_axis_pipe_reg: one-stage AXI4-Stream register with full throughput.
module osnt_axis_pipe_reg #(
    parameter int DATA_W = 256,
    parameter int USER_W = 128
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic [DATA_W-1:0]   i_s_tdata,
    input  logic [DATA_W/8-1:0] i_s_tstrb,
    input  logic [USER_W-1:0]   i_s_tuser,
    input  logic                i_s_tvalid,
    input  logic                i_s_tlast,
    output logic                o_s_tready,
    output logic [DATA_W-1:0]   o_m_tdata,
    output logic [DATA_W/8-1:0] o_m_tstrb,
    output logic [USER_W-1:0]   o_m_tuser,
    output logic                o_m_tvalid,
    output logic                o_m_tlast,
    input  logic                i_m_tready
);

    assign o_s_tready = !o_m_tvalid || i_m_tready;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_m_tdata  <= '0;
            o_m_tstrb  <= '0;
            o_m_tuser  <= '0;
            o_m_tlast  <= 1'b0;
            o_m_tvalid <= 1'b0;
        end else if (i_s_tvalid && o_s_tready) begin
            o_m_tdata  <= i_s_tdata;
            o_m_tstrb  <= i_s_tstrb;
            o_m_tuser  <= i_s_tuser;
            o_m_tlast  <= i_s_tlast;
            o_m_tvalid <= 1'b1;
        end else if (i_m_tready) begin
            o_m_tvalid <= 1'b0;
        end
    end

endmodule

// File: rtl/osnt_rate_monitor.sv
// osnt_rate_monitor: inline AXI4-Stream stage measuring bytes and packets per
// programmable cycle window, with saturating counters and snapshot outputs.
module osnt_rate_monitor
    import osnt_rate_monitor_pkg::*;
#(
    parameter int C_S_AXIS_DATA_WIDTH  = 256,
    parameter int C_S_AXIS_TUSER_WIDTH = 128,
    parameter int C_S_AXI_DATA_WIDTH   = 32,
    parameter int C_CNT_WIDTH          = 32
) (
    input  logic                              axi_aclk,
    input  logic                              axi_aresetn,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tstrb,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
    input  logic                              s_axis_tvalid,
    output logic                              s_axis_tready,
    input  logic                              s_axis_tlast,
    output logic [C_S_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
    output logic [C_S_AXIS_DATA_WIDTH/8-1:0]  m_axis_tstrb,
    output logic [C_S_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
    output logic                              m_axis_tvalid,
    output logic                              m_axis_tlast,
    input  logic                              m_axis_tready,
    input  logic                              sw_rst,
    input  logic                              mon_en,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     window_cycles,
    output logic [C_CNT_WIDTH-1:0]            bytes_last,
    output logic [C_CNT_WIDTH-1:0]            pkts_last,
    output logic                              sat_last,
    output logic                              window_done
);

    localparam int CW1 = C_S_AXI_DATA_WIDTH + 1;
    localparam logic [C_CNT_WIDTH-1:0] CNT_MAX = '1;

    state_t                        r_state, w_state_nxt;
    logic [C_S_AXI_DATA_WIDTH-1:0] r_cnt;
    logic [C_CNT_WIDTH-1:0]        r_bytes, r_pkts, w_bytes_nxt, w_pkts_nxt;
    logic [BYTE_CNT_W-1:0]         w_inc;
    logic                          r_sat, w_sat_nxt, w_acc, w_en, w_term, w_live, w_close;

    osnt_axis_pipe_reg #(
        .DATA_W (C_S_AXIS_DATA_WIDTH),
        .USER_W (C_S_AXIS_TUSER_WIDTH)
    ) u_pipe (
        .i_clk      (axi_aclk),
        .i_rst_n    (axi_aresetn),
        .i_s_tdata  (s_axis_tdata),
        .i_s_tstrb  (s_axis_tstrb),
        .i_s_tuser  (s_axis_tuser),
        .i_s_tvalid (s_axis_tvalid),
        .i_s_tlast  (s_axis_tlast),
        .o_s_tready (s_axis_tready),
        .o_m_tdata  (m_axis_tdata),
        .o_m_tstrb  (m_axis_tstrb),
        .o_m_tuser  (m_axis_tuser),
        .o_m_tvalid (m_axis_tvalid),
        .o_m_tlast  (m_axis_tlast),
        .i_m_tready (m_axis_tready)
    );

    assign w_acc       = s_axis_tvalid && s_axis_tready;
    assign w_en        = mon_en && (window_cycles != '0);
    assign w_inc       = w_acc ? popcount(STRB_W'(s_axis_tstrb)) : '0;
    assign w_bytes_nxt = C_CNT_WIDTH'(sat_add(64'(r_bytes), 64'(w_inc), C_CNT_WIDTH));
    assign w_pkts_nxt  = C_CNT_WIDTH'(sat_add(64'(r_pkts), 64'(w_acc && s_axis_tlast), C_CNT_WIDTH));
    assign w_sat_nxt   = r_sat || (w_bytes_nxt == CNT_MAX) || (w_pkts_nxt == CNT_MAX);
    // Terminal test uses >= so a lowered window_cycles closes the window at once.
    assign w_term      = (CW1'(r_cnt) + CW1'(1)) >= CW1'(window_cycles);

    always_comb begin
        w_state_nxt = (sw_rst || !w_en) ? IDLE : RUN;
        w_live      = (r_state == RUN) && w_en && !sw_rst;
        w_close     = w_live && w_term;
    end

    always_ff @(posedge axi_aclk) begin
        if (!axi_aresetn) r_state <= IDLE;
        else              r_state <= w_state_nxt;
    end

    always_ff @(posedge axi_aclk) begin
        if (!axi_aresetn || sw_rst) begin
            r_cnt       <= '0;
            r_bytes     <= '0;
            r_pkts      <= '0;
            r_sat       <= 1'b0;
            bytes_last  <= '0;
            pkts_last   <= '0;
            sat_last    <= 1'b0;
            window_done <= 1'b0;
        end else begin
            window_done <= w_close;
            if (!w_live) begin
                r_cnt   <= '0;
                r_bytes <= '0;
                r_pkts  <= '0;
                r_sat   <= 1'b0;
            end else if (w_term) begin
                bytes_last <= w_bytes_nxt;
                pkts_last  <= w_pkts_nxt;
                sat_last   <= w_sat_nxt;
                r_cnt      <= '0;
                r_bytes    <= '0;
                r_pkts     <= '0;
                r_sat      <= 1'b0;
            end else begin
                r_cnt   <= r_cnt + C_S_AXI_DATA_WIDTH'(1);
                r_bytes <= w_bytes_nxt;
                r_pkts  <= w_pkts_nxt;
                r_sat   <= w_sat_nxt;
            end
        end
    end

endmodule
